// File: rtl/imem_loader.sv
// Program loader and byte-wide instruction memory for the pipelined Y86-64 core.
// It loads a program from a valid/ready byte stream, then serves a 10-byte fetch window to the fetch stage.
module imem_loader #(
    parameter int MEM_BYTES = 2048,
    parameter int ADDR_W    = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic              in_ready,
    output logic              core_run,
    output logic              load_err,
    output logic [ADDR_W:0]   prog_len,
    input  logic [63:0]       rd_addr,
    output logic [79:0]       rd_data,
    output logic              imem_er
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_len;
    logic [7:0]        r_mem [MEM_BYTES];
    logic              w_accept;
    logic              w_at_end;
    logic [64:0]       w_sum;

    // load_start takes priority over a byte presented in the same cycle, so that byte is dropped
    assign w_accept = (r_state == LOAD) && in_valid && !load_start && !rst;
    assign w_at_end = (r_ptr == ADDR_W'(MEM_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (load_start) begin
            w_next = LOAD;
        end else if (r_state == LOAD && in_valid) begin
            if (in_last)       w_next = RUN;
            else if (w_at_end) w_next = ERR;
        end
    end

    always_comb begin
        in_ready = (r_state == LOAD);
        core_run = (r_state == RUN);
        load_err = (r_state == ERR);
        prog_len = r_len;
    end

    always_ff @(posedge clk) begin
        if (rst || load_start) begin
            r_ptr <= '0;
            r_len <= '0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_len <= {1'b0, r_ptr} + (ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_mem[r_ptr] <= in_byte;
    end

    // 65-bit sum keeps addresses near 2^64 from wrapping back into the loaded program
    always_comb begin
        rd_data = '0;
        w_sum   = '0;
        for (int unsigned k = 0; k < 10; k++) begin
            w_sum = {1'b0, rd_addr} + 65'(k);
            if (w_sum < 65'(r_len)) rd_data[8*k +: 8] = r_mem[w_sum[ADDR_W-1:0]];
        end
        imem_er = (r_state != RUN) || (rd_addr >= 64'(r_len)) || (rd_addr >= 64'(MEM_BYTES));
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a byte-level memory model predicts each fetch window,
// and expected windows are queued when the read address is driven and compared once it settles.
module tb_imem_loader;

    localparam int MB = 2048;

    typedef enum {M_IDLE, M_LOAD, M_RUN, M_ERR} mst_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_start = 1'b0;
    logic         in_valid = 1'b0;
    logic [7:0]   in_byte = '0;
    logic         in_last = 1'b0;
    logic         in_ready, core_run, load_err, imem_er;
    logic [11:0]  prog_len;
    logic [63:0]  rd_addr = '0;
    logic [79:0]  rd_data;

    int nvec = 0;
    int nerr = 0;

    logic [7:0]  mem_m [MB];
    int          len_m = 0;
    int          ptr_m = 0;
    mst_t        st_m  = M_IDLE;

    logic [80:0] exp_q [$];
    string       tag_q [$];

    imem_loader #(.MEM_BYTES(MB), .ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .load_start(load_start),
        .in_valid(in_valid), .in_byte(in_byte), .in_last(in_last),
        .in_ready(in_ready), .core_run(core_run), .load_err(load_err),
        .prog_len(prog_len), .rd_addr(rd_addr), .rd_data(rd_data), .imem_er(imem_er)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [80:0] obs, input logic [80:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".in_ready"}, 81'(in_ready), 81'(st_m == M_LOAD));
        chk({tag, ".core_run"}, 81'(core_run), 81'(st_m == M_RUN));
        chk({tag, ".load_err"}, 81'(load_err), 81'(st_m == M_ERR));
        chk({tag, ".prog_len"}, 81'(prog_len), 81'(len_m));
    endtask

    function automatic logic [80:0] mread(input logic [63:0] a);
        logic [79:0] d;
        logic        er;
        logic [64:0] s;
        d = '0;
        for (int k = 0; k < 10; k++) begin
            s = {1'b0, a} + 65'(k);
            if (s < 65'(len_m)) d[8*k +: 8] = mem_m[s[10:0]];
        end
        er = (st_m != M_RUN) || (a >= 64'(len_m)) || (a >= 64'(MB));
        return {er, d};
    endfunction

    // queue the predicted window, drive the address, then compare once settled
    task automatic rd(input string tag, input logic [63:0] a);
        logic [80:0] e;
        string       t;
        exp_q.push_back(mread(a));
        tag_q.push_back(tag);
        rd_addr = a;
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, {imem_er, rd_data}, e);
    endtask

    task automatic start();
        load_start = 1'b1;
        in_valid   = 1'b0;
        tick();
        load_start = 1'b0;
        st_m  = M_LOAD;
        ptr_m = 0;
        len_m = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (st_m == M_LOAD) begin
            mem_m[ptr_m] = b;
            ptr_m++;
            len_m = ptr_m;
            if (last)             st_m = M_RUN;
            else if (ptr_m == MB) st_m = M_ERR;
        end
    endtask

    task automatic gap(input logic [7:0] junk);
        in_valid = 1'b0;
        in_byte  = junk;
        in_last  = 1'b1;
        tick();
        in_last  = 1'b0;
    endtask

    task automatic load_irmovq();
        logic [7:0] prog [10];
        prog = '{8'h30, 8'hF4, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        start();
        for (int i = 0; i < 10; i++) send(prog[i], i == 9);
    endtask

    initial begin
        // reset
        tick();
        tick();
        rst = 1'b0;
        chk_status("reset");

        // basic 10-byte load
        start();
        chk_status("load_entry");
        load_irmovq();
        chk_status("basic_done");
        rd_addr = 64'd0;
        #1;
        chk("basic_rd0_const", {imem_er, rd_data}, {1'b0, 80'h00000000000000000F430});
        rd("basic_rd0", 64'd0);
        rd("boundary_rd5", 64'd5);
        rd("boundary_rd9", 64'd9);
        rd("boundary_rd10", 64'd10);
        rd("wrap_rd_top", 64'hFFFF_FFFF_FFFF_FFFC);
        rd("trunc_rd_2051", 64'd2051);

        // backpressure with gaps: valid 1,0,0,1,1
        start();
        send(8'hA1, 1'b0);
        gap(8'hEE);
        gap(8'hDD);
        chk_status("gap_mid");
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        chk_status("gap_done");
        rd("gap_rd0", 64'd0);
        chk("gap_rd0_const", 81'(rd_data), 81'(80'hA3A2A1));

        // reset mid-load
        start();
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b0);
        chk_status("midrst_pre");
        rst      = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'h77;
        tick();
        st_m  = M_IDLE;
        len_m = 0;
        ptr_m = 0;
        chk_status("midrst_in_rst");
        rst      = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk_status("midrst_after");
        rd("midrst_rd0", 64'd0);

        // overflow
        start();
        for (int i = 0; i < MB - 1; i++) send(8'((i * 7 + 3) & 8'hFF), 1'b0);
        chk_status("ovf_pre");
        send(8'h5A, 1'b0);
        chk_status("ovf_err");
        rd("ovf_rd0", 64'd0);
        rd("ovf_rd2046", 64'd2046);
        send(8'h99, 1'b1);
        chk_status("ovf_err_ignores");
        start();
        chk_status("ovf_reload");
        send(8'hC3, 1'b1);
        chk_status("ovf_recover");
        rd("ovf_recover_rd0", 64'd0);

        // reload from RUN, including a restart with a byte presented alongside load_start
        load_irmovq();
        chk_status("reload_base");
        start();
        chk_status("reload_load");
        send(8'h55, 1'b0);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_byte    = 8'h66;
        tick();
        load_start = 1'b0;
        in_valid   = 1'b0;
        ptr_m = 0;
        len_m = 0;
        chk_status("restart_drop");
        send(8'h00, 1'b1);
        chk_status("reload_done");
        rd("reload_rd0", 64'd0);
        rd("reload_rd1", 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
